// File: rtl/mem_stage_sb_pkg.sv
// Shared types and helpers for the MEM stage with store buffer: pipeline payloads,
// store-buffer entry, load FSM states, byte-enable generator and load-extend unit.
package mem_stage_sb_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  localparam logic [1:0] RESULT_ALU = 2'd0;
  localparam logic [1:0] RESULT_MEM = 2'd1;
  localparam logic [1:0] RESULT_PC4 = 2'd2;
  localparam logic [1:0] RESULT_IMM = 2'd3;

  typedef struct packed {
    logic            RegWrite;
    logic [1:0]      ResultSrc;
    logic            MemWrite;
    logic [2:0]      funct3;
    logic [XLEN-1:0] ALUResult;
    logic [XLEN-1:0] WriteData;
    logic [4:0]      Rd;
    logic [XLEN-1:0] PCPlus4;
    logic [XLEN-1:0] ImmExt;
  } exmem_t;

  typedef struct packed {
    logic            RegWrite;
    logic [1:0]      ResultSrc;
    logic [XLEN-1:0] ALUResult;
    logic [XLEN-1:0] load_data;
    logic [4:0]      Rd;
    logic [XLEN-1:0] PCPlus4;
    logic [XLEN-1:0] ImmExt;
  } memwb_t;

  typedef struct packed {
    logic [XLEN-3:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} ld_state_e;

  // Byte enables for a store, and the byte mask a load needs: width from funct3[1:0].
  function automatic logic [BE_W-1:0] byte_enable(input logic [2:0] funct3,
                                                  input logic [1:0] offset);
    logic [BE_W-1:0] base;
    case (funct3[1:0])
      2'b00:   base = BE_W'(1);
      2'b01:   base = BE_W'(3);
      default: base = {BE_W{1'b1}};
    endcase
    return base << offset;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [2:0]      funct3,
                                                  input logic [1:0]      offset);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = word >> {offset, 3'b000};
    case (funct3)
      3'b000:  res = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  res = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b100:  res = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  res = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_sb_if.sv
// Data-memory port: request/grant for reads and posted writes, one rvalid per granted read.
interface mem_stage_sb_if #(
  parameter int XLEN = 32
);
  logic              req;
  logic              we;
  logic [XLEN-3:0]   addr;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_sb_store_buffer.sv
// Circular store buffer with a parallel address match used for load forwarding.
module store_buffer
  import mem_stage_sb_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  sb_entry_t       push_entry,
  input  logic [XLEN-3:0] lookup_addr,
  input  logic [BE_W-1:0] lookup_mask,
  output logic            full,
  output logic            empty,
  output sb_entry_t       head_entry,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_data,
  output logic            conflict
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        entries [SB_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;
  logic             any_match;
  logic             young_cover;
  logic [PTR_W-1:0] idx;

  assign full       = (count == CNT_W'(SB_DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign head_entry = entries[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) entries[tail] <= push_entry;
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    any_match   = 1'b0;
    young_cover = 1'b0;
    fwd_data    = '0;
    idx         = head;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[idx].addr == lookup_addr)) begin
        any_match   = 1'b1;
        young_cover = ((entries[idx].be & lookup_mask) == lookup_mask);
        fwd_data    = entries[idx].data;
      end
    end
    fwd_hit  = any_match & young_cover;
    conflict = any_match & ~young_cover;
  end

endmodule

// File: rtl/mem_stage_sb.sv
// Pipeline MEM stage: stores retire into a store buffer that drains in the background;
// loads forward from the buffer or run a request/grant/rvalid read while stalling.
module mem_stage_sb #(
  parameter int SB_DEPTH = 4,
  parameter int XLEN     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  mem_stage_sb_pkg::exmem_t inputs,
  output mem_stage_sb_pkg::memwb_t outputs,
  output logic                     out_valid,
  output logic                     stall_m,
  output logic                     sb_empty,
  output logic [4:0]               RdM,
  output logic                     RegWriteM,
  output logic [XLEN-1:0]          ALUResultM,
  mem_stage_sb_if.master           mem
);
  import mem_stage_sb_pkg::*;

  ld_state_e       state;
  ld_state_e       state_nxt;
  logic            is_store;
  logic            is_load;
  logic            sb_full;
  logic            fwd_hit;
  logic            conflict;
  logic            push;
  logic            pop;
  logic            drain;
  logic            rd_req;
  logic            stall;
  logic [XLEN-1:0] fwd_data;
  logic [XLEN-1:0] rdata_q;
  logic [BE_W-1:0] ld_mask;
  sb_entry_t       push_entry;
  sb_entry_t       head_entry;

  assign is_store   = in_valid & inputs.MemWrite;
  assign is_load    = in_valid & ~inputs.MemWrite & (inputs.ResultSrc == RESULT_MEM);
  assign ld_mask    = byte_enable(inputs.funct3, inputs.ALUResult[1:0]);
  assign push_entry = '{addr: inputs.ALUResult[XLEN-1:2],
                        be:   byte_enable(inputs.funct3, inputs.ALUResult[1:0]),
                        data: inputs.WriteData};

  store_buffer #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .pop         (pop),
    .push_entry  (push_entry),
    .lookup_addr (inputs.ALUResult[XLEN-1:2]),
    .lookup_mask (ld_mask),
    .full        (sb_full),
    .empty       (sb_empty),
    .head_entry  (head_entry),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .conflict    (conflict)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           rdata_q <= '0;
    else if (state == WAIT && mem.rvalid) rdata_q <= mem.rdata;
  end

  // A bus load beats the drain unless the buffer is full; nothing drains outside IDLE.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    push      = 1'b0;
    drain     = 1'b0;
    rd_req    = 1'b0;
    case (state)
      IDLE: begin
        drain = ~sb_empty;
        if (is_store) begin
          push  = ~sb_full;
          stall = sb_full;
        end else if (is_load && !fwd_hit) begin
          stall = 1'b1;
          if (!conflict && !sb_full) begin
            drain     = 1'b0;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        stall  = 1'b1;
        rd_req = 1'b1;
        if (mem.gnt) state_nxt = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (mem.rvalid) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pop       = drain & mem.gnt;
  assign mem.req   = drain | rd_req;
  assign mem.we    = drain;
  assign mem.addr  = rd_req ? inputs.ALUResult[XLEN-1:2] : head_entry.addr;
  assign mem.be    = rd_req ? {BE_W{1'b1}} : head_entry.be;
  assign mem.wdata = head_entry.data;

  assign stall_m    = stall;
  assign out_valid  = in_valid & ~stall;
  assign RdM        = inputs.Rd;
  assign RegWriteM  = inputs.RegWrite;
  assign ALUResultM = inputs.ALUResult;

  assign outputs = '{RegWrite:  inputs.RegWrite,
                     ResultSrc: inputs.ResultSrc,
                     ALUResult: inputs.ALUResult,
                     load_data: load_extend((state == DONE) ? rdata_q : fwd_data,
                                            inputs.funct3, inputs.ALUResult[1:0]),
                     Rd:        inputs.Rd,
                     PCPlus4:   inputs.PCPlus4,
                     ImmExt:    inputs.ImmExt};

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb: forwarding, conflicts, full buffer, bus-load latency,
// drain/load arbitration and reset during an outstanding read.
module tb_mem_stage_sb;
  import mem_stage_sb_pkg::*;

  logic   clk      = 1'b0;
  logic   rst_n    = 1'b0;
  logic   in_valid = 1'b0;
  exmem_t inputs   = '0;
  memwb_t outputs;
  logic   out_valid;
  logic   stall_m;
  logic   sb_empty;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic [31:0] ALUResultM;
  int checks = 0;
  int errors = 0;

  mem_stage_sb_if #(.XLEN(32)) mem_bus ();

  mem_stage_sb #(.SB_DEPTH(4), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .inputs     (inputs),
    .outputs    (outputs),
    .out_valid  (out_valid),
    .stall_m    (stall_m),
    .sb_empty   (sb_empty),
    .RdM        (RdM),
    .RegWriteM  (RegWriteM),
    .ALUResultM (ALUResultM),
    .mem        (mem_bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exmem_t mk_op(input logic st, input logic ld, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd);
    exmem_t op = '0;
    op.MemWrite  = st;
    op.ResultSrc = ld ? RESULT_MEM : RESULT_ALU;
    op.RegWrite  = ld;
    op.funct3    = f3;
    op.ALUResult = addr;
    op.WriteData = wd;
    op.Rd        = 5'd10;
    op.PCPlus4   = 32'h0000_1004;
    op.ImmExt    = 32'h0000_0010;
    return op;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid       = 1'b0;
    inputs         = '0;
    mem_bus.gnt    = 1'b0;
    mem_bus.rvalid = 1'b0;
    mem_bus.rdata  = '0;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_sb_empty: got %b want 1", sb_empty); end
    checks++; if (mem_bus.req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_bus.req); end
    checks++; if (stall_m !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b want 0", stall_m); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    exmem_t op;
    do_reset();
    next_cycle();
    op = mk_op(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0);
    op.RegWrite = 1'b1;
    op.Rd = 5'd7;
    in_valid = 1'b1;
    inputs = op;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || stall_m !== 1'b0) begin errors++; $display("[TB] FAIL pass_valid: got ov=%b st=%b want ov=1 st=0", out_valid, stall_m); end
    checks++; if (outputs.ALUResult !== 32'h1234_5678 || outputs.Rd !== 5'd7 || outputs.PCPlus4 !== 32'h0000_1004 || outputs.ImmExt !== 32'h10) begin errors++; $display("[TB] FAIL pass_fields: got alu=%h rd=%0d pc4=%h imm=%h", outputs.ALUResult, outputs.Rd, outputs.PCPlus4, outputs.ImmExt); end
    checks++; if (RdM !== 5'd7 || RegWriteM !== 1'b1 || ALUResultM !== 32'h1234_5678) begin errors++; $display("[TB] FAIL pass_hazard: got rd=%0d rw=%b alu=%h want 7 1 12345678", RdM, RegWriteM, ALUResultM); end
    checks++; if (mem_bus.req !== 1'b0) begin errors++; $display("[TB] FAIL pass_mem_req: got %b want 0", mem_bus.req); end
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_forward();
    do_reset();
    next_cycle();
    in_valid = 1'b1;
    inputs = mk_op(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++; if (stall_m !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fwd_store: got st=%b ov=%b want 0 1", stall_m, out_valid); end
    next_cycle();
    inputs = mk_op(1'b0, 1'b1, 3'b010, 32'h100, 32'h0);
    @(negedge clk);
    checks++; if (stall_m !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fwd_load: got st=%b ov=%b want 0 1", stall_m, out_valid); end
    checks++; if (outputs.load_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL fwd_data: got %h want deadbeef", outputs.load_data); end
    checks++; if (mem_bus.req !== 1'b1 || mem_bus.we !== 1'b1) begin errors++; $display("[TB] FAIL fwd_no_read: got req=%b we=%b want req=1 we=1", mem_bus.req, mem_bus.we); end
    checks++; if (mem_bus.addr !== 30'h40 || mem_bus.be !== 4'hF || mem_bus.wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL fwd_drain_head: got a=%h be=%h d=%h want 40 f deadbeef", mem_bus.addr, mem_bus.be, mem_bus.wdata); end
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_conflict();
    do_reset();
    next_cycle();
    in_valid = 1'b1;
    inputs = mk_op(1'b1, 1'b0, 3'b000, 32'h101, 32'h0000_AA00);
    next_cycle();
    inputs = mk_op(1'b0, 1'b1, 3'b010, 32'h100, 32'h0);
    @(negedge clk);
    checks++; if (stall_m !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL cfl_stall: got st=%b ov=%b want 1 0", stall_m, out_valid); end
    checks++; if (mem_bus.req !== 1'b1 || mem_bus.we !== 1'b1 || mem_bus.be !== 4'b0010) begin errors++; $display("[TB] FAIL cfl_drain: got req=%b we=%b be=%b want 1 1 0010", mem_bus.req, mem_bus.we, mem_bus.be); end
    next_cycle();
    mem_bus.gnt = 1'b1;
    @(negedge clk);
    checks++; if (stall_m !== 1'b1) begin errors++; $display("[TB] FAIL cfl_hold: got %b want 1", stall_m); end
    next_cycle();
    mem_bus.gnt = 1'b0;
    @(negedge clk);
    checks++; if (stall_m !== 1'b1 || mem_bus.req !== 1'b0) begin errors++; $display("[TB] FAIL cfl_idle_issue: got st=%b req=%b want 1 0", stall_m, mem_bus.req); end
    next_cycle();
    mem_bus.gnt = 1'b1;
    @(negedge clk);
    checks++; if (mem_bus.req !== 1'b1 || mem_bus.we !== 1'b0 || mem_bus.addr !== 30'h40 || mem_bus.be !== 4'hF) begin errors++; $display("[TB] FAIL cfl_read_req: got req=%b we=%b a=%h be=%h want 1 0 40 f", mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.be); end
    next_cycle();
    mem_bus.gnt = 1'b0;
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata = 32'h1122_AA44;
    next_cycle();
    mem_bus.rvalid = 1'b0;
    @(negedge clk);
    checks++; if (stall_m !== 1'b0 || out_valid !== 1'b1 || outputs.load_data !== 32'h1122_AA44) begin errors++; $display("[TB] FAIL cfl_done: got st=%b ov=%b d=%h want 0 1 1122aa44", stall_m, out_valid, outputs.load_data); end
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_full();
    logic [31:0] wd;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      wd = 32'h1111_1111 * (k + 1);
      in_valid = 1'b1;
      inputs = mk_op(1'b1, 1'b0, 3'b010, 32'h10 * (k + 1), wd);
      @(negedge clk);
      checks++; if (stall_m !== (k == 4)) begin errors++; $display("[TB] FAIL full_store%0d: got st=%b want %b", k, stall_m, k == 4); end
    end
    next_cycle();
    mem_bus.gnt = 1'b1;
    @(negedge clk);
    checks++; if (stall_m !== 1'b1 || mem_bus.addr !== 30'h4) begin errors++; $display("[TB] FAIL full_pop_same_cycle: got st=%b a=%h want 1 4", stall_m, mem_bus.addr); end
    next_cycle();
    mem_bus.gnt = 1'b0;
    @(negedge clk);
    checks++; if (stall_m !== 1'b0) begin errors++; $display("[TB] FAIL full_push_next: got %b want 0", stall_m); end
    next_cycle();
    in_valid = 1'b0;
    mem_bus.gnt = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      wd = 32'h1111_1111 * (j + 2);
      checks++; if (mem_bus.req !== 1'b1 || mem_bus.we !== 1'b1 || mem_bus.addr !== 30'((32'h10 * (j + 2)) >> 2) || mem_bus.wdata !== wd) begin errors++; $display("[TB] FAIL full_drain%0d: got req=%b we=%b a=%h d=%h want d=%h", j, mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata, wd); end
      next_cycle();
    end
    mem_bus.gnt = 1'b0;
    @(negedge clk);
    checks++; if (sb_empty !== 1'b1 || mem_bus.req !== 1'b0) begin errors++; $display("[TB] FAIL full_empty: got empty=%b req=%b want 1 0", sb_empty, mem_bus.req); end
  endtask

  task automatic test_miss_latency();
    int stall_cnt = 0;
    int ov_cnt = 0;
    int req_cnt = 0;
    logic [31:0] ld_got = '0;
    do_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      next_cycle();
      in_valid = (cyc <= 6);
      inputs = mk_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h0);
      mem_bus.gnt = (cyc == 2);
      mem_bus.rvalid = (cyc == 5);
      mem_bus.rdata = 32'h8001_1234;
      @(negedge clk);
      if (stall_m) stall_cnt++;
      if (out_valid) begin ov_cnt++; ld_got = outputs.load_data; end
      if (mem_bus.req && !mem_bus.we) req_cnt++;
    end
    in_valid = 1'b0;
    mem_bus.gnt = 1'b0;
    mem_bus.rvalid = 1'b0;
    checks++; if (stall_cnt != 6) begin errors++; $display("[TB] FAIL miss_stall_cycles: got %0d want 6", stall_cnt); end
    checks++; if (ov_cnt != 1) begin errors++; $display("[TB] FAIL miss_out_valid: got %0d pulses want 1", ov_cnt); end
    checks++; if (req_cnt != 2) begin errors++; $display("[TB] FAIL miss_req_cycles: got %0d want 2", req_cnt); end
    checks++; if (ld_got !== 32'hFFFF_8001) begin errors++; $display("[TB] FAIL miss_lh_data: got %h want ffff8001", ld_got); end
  endtask

  task automatic test_full_and_miss();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      in_valid = 1'b1;
      inputs = mk_op(1'b1, 1'b0, 3'b010, 32'h300 + 32'(4 * k), 32'hA000_0000 + 32'(k));
    end
    next_cycle();
    inputs = mk_op(1'b0, 1'b1, 3'b010, 32'h400, 32'h0);
    mem_bus.gnt = 1'b1;
    @(negedge clk);
    checks++; if (mem_bus.req !== 1'b1 || mem_bus.we !== 1'b1 || mem_bus.addr !== 30'hC0 || stall_m !== 1'b1) begin errors++; $display("[TB] FAIL arb_drain_first: got req=%b we=%b a=%h st=%b want 1 1 c0 1", mem_bus.req, mem_bus.we, mem_bus.addr, stall_m); end
    next_cycle();
    mem_bus.gnt = 1'b0;
    @(negedge clk);
    checks++; if (mem_bus.req !== 1'b0 || stall_m !== 1'b1) begin errors++; $display("[TB] FAIL arb_load_wins: got req=%b st=%b want 0 1", mem_bus.req, stall_m); end
    next_cycle();
    mem_bus.gnt = 1'b1;
    @(negedge clk);
    checks++; if (mem_bus.req !== 1'b1 || mem_bus.we !== 1'b0 || mem_bus.addr !== 30'h100) begin errors++; $display("[TB] FAIL arb_read_req: got req=%b we=%b a=%h want 1 0 100", mem_bus.req, mem_bus.we, mem_bus.addr); end
    next_cycle();
    mem_bus.gnt = 1'b0;
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata = 32'hCAFE_F00D;
    next_cycle();
    mem_bus.rvalid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || outputs.load_data !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL arb_done: got ov=%b d=%h want 1 cafef00d", out_valid, outputs.load_data); end
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      in_valid = 1'b1;
      inputs = mk_op(1'b1, 1'b0, 3'b010, 32'h500 + 32'(4 * k), 32'h5555_0000 + 32'(k));
    end
    next_cycle();
    inputs = mk_op(1'b0, 1'b1, 3'b010, 32'h700, 32'h0);
    @(negedge clk);
    checks++; if (mem_bus.req !== 1'b0 || stall_m !== 1'b1) begin errors++; $display("[TB] FAIL rstw_load_first: got req=%b st=%b want 0 1", mem_bus.req, stall_m); end
    next_cycle();
    mem_bus.gnt = 1'b1;
    next_cycle();
    mem_bus.gnt = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (sb_empty !== 1'b1 || mem_bus.req !== 1'b0 || stall_m !== 1'b0) begin errors++; $display("[TB] FAIL rstw_cleared: got empty=%b req=%b st=%b want 1 0 0", sb_empty, mem_bus.req, stall_m); end
    next_cycle();
    rst_n = 1'b1;
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata = 32'h0000_0BAD;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || stall_m !== 1'b0 || mem_bus.req !== 1'b0 || sb_empty !== 1'b1) begin errors++; $display("[TB] FAIL rstw_late_rvalid: got ov=%b st=%b req=%b empty=%b want 0 0 0 1", out_valid, stall_m, mem_bus.req, sb_empty); end
    next_cycle();
    mem_bus.rvalid = 1'b0;
    in_valid = 1'b1;
    inputs = mk_op(1'b0, 1'b1, 3'b010, 32'h800, 32'h0);
    @(negedge clk);
    checks++; if (stall_m !== 1'b1 || mem_bus.req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstw_idle: got st=%b req=%b ov=%b want 1 0 0", stall_m, mem_bus.req, out_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (mem_bus.req !== 1'b1 || mem_bus.we !== 1'b0 || mem_bus.addr !== 30'h200) begin errors++; $display("[TB] FAIL rstw_new_req: got req=%b we=%b a=%h want 1 0 200", mem_bus.req, mem_bus.we, mem_bus.addr); end
    next_cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_forward();
    test_conflict();
    test_full();
    test_miss_latency();
    test_full_and_miss();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
